// File: rtl/fm_phase_sweeper.sv
// fm_phase_sweeper: time-multiplexed phase-accumulator engine. A rising edge of the
// sample tick sweeps every operator slot: fetch increment and flags, advance the
// phase, write it back and drive the square-wave channel pins.
module fm_phase_sweeper #(
  parameter int unsigned ACC_RESOLUTION = 22,
  parameter int unsigned N_VOICES       = 16,
  parameter int unsigned N_OPS          = 6,
  parameter int unsigned TICKS_PER_OP   = 4,
  parameter int unsigned N_CHAN         = 8,
  parameter int unsigned ADDR_W         = 10
) (
  input  logic                      IO_main_clk,
  input  logic                      IO_rst,
  input  logic                      IO_audio_clk,
  output logic [ADDR_W-1:0]         IO_User_Mem_addr,
  input  logic [ACC_RESOLUTION-1:0] IO_User_Mem_value,
  output logic [ADDR_W-1:0]         IO_Flag_addr,
  input  logic [1:0]                IO_Flag_value,
  output logic [N_CHAN-1:0]         IO_chan,
  output logic                      IO_busy,
  output logic                      IO_sweep_done,
  output logic                      IO_overrun
);

  localparam int unsigned S     = N_VOICES * N_OPS;
  localparam int unsigned IDX_W = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned PH_W  = $clog2(TICKS_PER_OP);

  localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(S - 1);
  localparam logic [PH_W-1:0]   LAST_PH   = PH_W'(TICKS_PER_OP - 1);
  localparam logic [PH_W-1:0]   PH1       = PH_W'(1);
  localparam logic [PH_W-1:0]   PH2       = PH_W'(2);
  localparam logic [PH_W-1:0]   PH3       = PH_W'(3);

  typedef enum logic [1:0] {CLEAR, IDLE, SWEEP} state_t;

  state_t                    state, state_n;
  logic [ADDR_W-1:0]         slot, slot_n;
  logic [PH_W-1:0]           ph, ph_n;
  logic                      tick_q;
  logic                      start;
  logic                      busy_n, done_n, overrun_n;

  logic [ACC_RESOLUTION-1:0] mem [S];
  logic [ACC_RESOLUTION-1:0] rd_data;
  logic                      wr_en;
  logic [ACC_RESOLUTION-1:0] wr_data;
  logic [IDX_W-1:0]          slot_idx;

  logic [ACC_RESOLUTION-1:0] inc, acc_old, acc_new;
  logic                      gate, prst;

  assign start    = IO_audio_clk & ~tick_q;
  assign slot_idx = slot[IDX_W-1:0];

  // Next-state and next-value logic for the sweep sequencer.
  always_comb begin
    state_n   = state;
    slot_n    = slot;
    ph_n      = ph;
    busy_n    = IO_busy;
    done_n    = 1'b0;
    overrun_n = IO_overrun;
    case (state)
      CLEAR: begin
        slot_n = slot + ADDR_W'(1);
        if (slot == LAST_SLOT) begin
          state_n = IDLE;
          slot_n  = '0;
          busy_n  = 1'b0;
        end
      end
      IDLE: begin
        if (start) begin
          state_n = SWEEP;
          slot_n  = '0;
          ph_n    = '0;
          busy_n  = 1'b1;
        end
      end
      SWEEP: begin
        if (start) overrun_n = 1'b1;
        if (ph == LAST_PH) begin
          ph_n = '0;
          if (slot == LAST_SLOT) begin
            slot_n  = '0;
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            slot_n = slot + ADDR_W'(1);
          end
        end else begin
          ph_n = ph + PH_W'(1);
        end
      end
      default: state_n = CLEAR;
    endcase
  end

  // Sequencer registers; addresses load with the next slot so they are
  // already stable during ph0 and the external registered read lands in ph1.
  always_ff @(posedge IO_main_clk) begin
    if (IO_rst) begin
      state            <= CLEAR;
      slot             <= '0;
      ph               <= '0;
      tick_q           <= 1'b0;
      IO_busy          <= 1'b1;
      IO_sweep_done    <= 1'b0;
      IO_overrun       <= 1'b0;
      IO_User_Mem_addr <= '0;
      IO_Flag_addr     <= '0;
    end else begin
      state            <= state_n;
      slot             <= slot_n;
      ph               <= ph_n;
      tick_q           <= IO_audio_clk;
      IO_busy          <= busy_n;
      IO_sweep_done    <= done_n;
      IO_overrun       <= overrun_n;
      IO_User_Mem_addr <= slot_n;
      IO_Flag_addr     <= slot_n;
    end
  end

  assign wr_en   = (state == CLEAR) || ((state == SWEEP) && (ph == PH3));
  assign wr_data = (state == CLEAR) ? '0 : acc_new;

  // Phase storage: one write port, one registered read port, no reset.
  always_ff @(posedge IO_main_clk) begin
    if (wr_en) mem[slot_idx] <= wr_data;
    rd_data <= mem[slot_idx];
  end

  // Per-slot datapath: latch operands, compute the new phase, drive channel pins.
  always_ff @(posedge IO_main_clk) begin
    if (IO_rst) begin
      IO_chan <= '0;
      inc     <= '0;
      acc_old <= '0;
      acc_new <= '0;
      gate    <= 1'b0;
      prst    <= 1'b0;
    end else if (state == SWEEP) begin
      if (ph == PH1) begin
        inc     <= IO_User_Mem_value;
        gate    <= IO_Flag_value[0];
        prst    <= IO_Flag_value[1];
        acc_old <= rd_data;
      end
      if (ph == PH2) begin
        acc_new <= prst ? '0 : (gate ? acc_old + inc : acc_old);
      end
      if (ph == PH3) begin
        for (int unsigned k = 0; k < N_CHAN; k++) begin
          if (slot == ADDR_W'(k)) IO_chan[k] <= acc_new[ACC_RESOLUTION-1];
        end
      end
    end
  end

endmodule

// File: tb/tb_fm_phase_sweeper.sv
// Testbench for fm_phase_sweeper: random and directed sweeps checked by a
// scoreboard against a slot-by-slot arithmetic model of the phase array.
module tb_fm_phase_sweeper;

  localparam int AW  = 8;
  localparam int NV  = 2;
  localparam int NO  = 2;
  localparam int TPO = 4;
  localparam int NC  = 4;
  localparam int ADW = 4;
  localparam int S   = NV * NO;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           tick = 1'b0;
  logic [ADW-1:0] mem_addr, flag_addr;
  logic [AW-1:0]  user_val;
  logic [1:0]     flag_val;
  logic [NC-1:0]  chan;
  logic           busy, done, ovr;

  fm_phase_sweeper #(
    .ACC_RESOLUTION(AW), .N_VOICES(NV), .N_OPS(NO),
    .TICKS_PER_OP(TPO), .N_CHAN(NC), .ADDR_W(ADW)
  ) dut (
    .IO_main_clk(clk), .IO_rst(rst), .IO_audio_clk(tick),
    .IO_User_Mem_addr(mem_addr), .IO_User_Mem_value(user_val),
    .IO_Flag_addr(flag_addr), .IO_Flag_value(flag_val),
    .IO_chan(chan), .IO_busy(busy), .IO_sweep_done(done), .IO_overrun(ovr)
  );

  always #5 clk = ~clk;

  // External increment / flag memories with registered reads.
  logic [AW-1:0] inc_mem  [16];
  logic [1:0]    flag_mem [16];
  always @(posedge clk) begin
    user_val <= inc_mem[mem_addr];
    flag_val <= flag_mem[flag_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [NC-1:0] chan;
    int            due;
  } exp_t;
  exp_t q[$];

  logic [AW-1:0] model_acc [S];
  bit            model_ovr = 1'b0;
  int            checks = 0;
  int            passed = 0;
  int            done_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One sweep of the reference: each slot resets, advances mod 2**AW, or holds.
  function automatic logic [NC-1:0] model_sweep();
    logic [NC-1:0] ch;
    for (int s = 0; s < S; s++) begin
      if (flag_mem[s][1]) model_acc[s] = '0;
      else if (flag_mem[s][0])
        model_acc[s] = AW'((int'(model_acc[s]) + int'(inc_mem[s])) % (1 << AW));
    end
    for (int k = 0; k < NC; k++) ch[k] = model_acc[k][AW-1];
    return ch;
  endfunction

  // Monitor: every sweep_done pulse is matched to the oldest expected sweep.
  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      if (q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: got pulse expected none (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("chan", chan, e.chan);
        chk("latency", cyc, e.due);
        chk("busy_at_done", busy, 0);
        chk("overrun_at_done", ovr, model_ovr);
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (n >= 400) begin
      checks++;
      $display("FAIL idle_timeout: got busy=%0b pending=%0d expected idle", busy, q.size());
    end
  endtask

  // Issue one tick edge from idle and wait for its sweep to complete.
  task automatic sweep(input int hold);
    exp_t e;
    e.chan = model_sweep();
    e.due  = cyc + 1 + S * TPO;
    q.push_back(e);
    tick = 1'b1;
    repeat (hold) @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    wait_idle();
  endtask

  initial begin
    logic [3:0] t2_exp;
    int         n;
    int         d0;
    t2_exp = 4'b0110;
    for (int i = 0; i < 16; i++) begin
      inc_mem[i]  = '0;
      flag_mem[i] = '0;
    end
    for (int s = 0; s < S; s++) model_acc[s] = '0;

    // T1: reset then clear phase
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("busy_clear_cycles", n, S);
    chk("chan_after_reset", chan, 0);
    chk("overrun_after_reset", ovr, 0);
    repeat (2) @(negedge clk);

    // T2: slot0 +0x40 per sweep, MSB 0,1,1,0
    inc_mem[0] = 8'h40; flag_mem[0] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      sweep(1 + $urandom_range(0, 2));
      chk("t2_chan0", chan[0], t2_exp[i]);
    end

    // T3: slot1 gated off, then on
    flag_mem[0] = 2'b00;
    inc_mem[1] = 8'hC0; flag_mem[1] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      sweep(1);
      chk("t3_chan1_gated", chan[1], 0);
    end
    flag_mem[1] = 2'b01;
    sweep(2);
    chk("t3_chan1_open", chan[1], 1);

    // T4: phase reset beats gate
    flag_mem[1] = 2'b00;
    flag_mem[0] = 2'b01;
    sweep(1);
    sweep(1);
    chk("t4_chan0_at_80", chan[0], 1);
    flag_mem[0] = 2'b11;
    sweep(1);
    chk("t4_chan0_reset", chan[0], 0);
    flag_mem[0] = 2'b01;
    sweep(1);
    chk("t4_chan0_from_zero", chan[0], 0);

    // T5: second tick edge mid-sweep
    d0 = done_cnt;
    begin
      exp_t e;
      e.chan = model_sweep();
      e.due  = cyc + 1 + S * TPO;
      q.push_back(e);
    end
    tick = 1'b1;
    repeat (2) @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    model_ovr = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_idle();
    repeat (4) @(negedge clk);
    chk("t5_overrun", ovr, 1);
    chk("t5_single_done", done_cnt - d0, 1);
    sweep(1);
    chk("t5_overrun_sticky", ovr, 1);

    // T6: reset mid-sweep, edge during clear ignored
    inc_mem[2] = 8'h90; flag_mem[2] = 2'b01;
    sweep(1);
    chk("t6_chan2_before", chan[2], 1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    for (int s = 0; s < S; s++) model_acc[s] = '0;
    model_ovr = 1'b0;
    chk("t6_chan", chan, 0);
    chk("t6_overrun", ovr, 0);
    chk("t6_busy", busy, 1);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("t6_clear_edge_no_overrun", ovr, 0);
    sweep(1);

    // Randomized sweeps
    for (int it = 0; it < 20; it++) begin
      for (int s = 0; s < S; s++) begin
        int r;
        r = $urandom_range(0, 9);
        inc_mem[s]  = AW'($urandom);
        flag_mem[s] = (r < 6) ? 2'b01 : (r < 8) ? 2'b00 : (r == 8) ? 2'b10 : 2'b11;
      end
      sweep(1 + $urandom_range(0, 2));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
